// File: rtl/booth_iter_counter.sv
// Iteration counter and IDLE/RUN/DONE sequencer for the Booth multiplier.
// Counts remaining bits down by 1 (radix-2) or 2 (radix-4) with hold/abort.
module booth_iter_counter #(
   parameter int N = 16,
   localparam int CW = $clog2(N + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          radix4,
   input  logic          hold,
   input  logic          abort,
   output logic [CW-1:0] dout,
   output logic [CW-1:0] iter,
   output logic          busy,
   output logic          last,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Odd widths get one sign-extension bit so radix-4 steps divide evenly.
   localparam logic [CW-1:0] LOAD_R2 = CW'(N);
   localparam logic [CW-1:0] LOAD_R4 = CW'(N + (N % 2));
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] TWO     = CW'(2);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] dout_nxt;
   logic [CW-1:0] iter_nxt;
   logic          step2;
   logic          step2_nxt;
   logic [CW-1:0] step;

   assign step = step2 ? TWO : ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dout  <= '0;
         iter  <= '0;
         step2 <= 1'b0;
      end else begin
         state <= state_nxt;
         dout  <= dout_nxt;
         iter  <= iter_nxt;
         step2 <= step2_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dout_nxt  = dout;
      iter_nxt  = iter;
      step2_nxt = step2;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               dout_nxt  = radix4 ? LOAD_R4 : LOAD_R2;
               iter_nxt  = '0;
               step2_nxt = radix4;
            end else if (state == DONE) begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               dout_nxt  = '0;
            end else if (!hold && (dout >= step)) begin
               dout_nxt = dout - step;
               iter_nxt = iter + ONE;
               if (dout == step) begin
                  state_nxt = DONE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            dout_nxt  = '0;
         end
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign last = busy && (dout == step);

endmodule

// File: tb/tb_booth_iter_counter.sv
// Bench for booth_iter_counter: directed table, corner sequences and
// randomized traffic checked against an iteration-count reference model.
module tb_booth_iter_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       radix4 = 1'b0;
   logic       hold = 1'b0;
   logic       abort = 1'b0;

   logic [4:0] a_dout, a_iter;
   logic       a_busy, a_last, a_done;
   logic [4:0] b_dout, b_iter;
   logic       b_busy, b_last, b_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   booth_iter_counter #(.N(16)) dut16 (
      .clk(clk), .rst(rst), .start(start), .radix4(radix4),
      .hold(hold), .abort(abort), .dout(a_dout), .iter(a_iter),
      .busy(a_busy), .last(a_last), .done(a_done)
   );

   booth_iter_counter #(.N(15)) dut15 (
      .clk(clk), .rst(rst), .start(start), .radix4(radix4),
      .hold(hold), .abort(abort), .dout(b_dout), .iter(b_iter),
      .busy(b_busy), .last(b_last), .done(b_done)
   );

   // Model: a run is "k of tot iterations done"; dout is derived arithmetically.
   typedef struct {
      bit run;
      bit dn;
      int k;
      int tot;
      int s;
      int ld;
   } mdl_t;

   localparam mdl_t MRST = '{run: 1'b0, dn: 1'b0, k: 0, tot: 1, s: 1, ld: 0};

   mdl_t m16 = MRST;
   mdl_t m15 = MRST;

   function automatic mdl_t nxt(mdl_t m, bit st, bit r4, bit hd, bit ab,
                                int n);
      mdl_t r = m;
      r.dn = 1'b0;
      if (m.run) begin
         if (ab) begin
            r.run = 1'b0;
         end else if (!hd) begin
            r.k = m.k + 1;
            if (r.k == m.tot) begin
               r.run = 1'b0;
               r.dn  = 1'b1;
            end
         end
      end else if (st) begin
         r.run = 1'b1;
         r.k   = 0;
         r.s   = r4 ? 2 : 1;
         r.ld  = r4 ? ((n + 1) / 2) * 2 : n;
         r.tot = r.ld / r.s;
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m16 <= MRST;
         m15 <= MRST;
      end else begin
         m16 <= nxt(m16, start, radix4, hold, abort, 16);
         m15 <= nxt(m15, start, radix4, hold, abort, 15);
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_one(string tag, mdl_t m, logic [4:0] d, logic [4:0] it,
                          logic bz, logic ls, logic dn);
      chk({tag, " dout"}, 32'(d), m.run ? m.ld - m.k * m.s : 0);
      chk({tag, " iter"}, 32'(it), m.k);
      chk({tag, " busy"}, 32'(bz), 32'(m.run));
      chk({tag, " last"}, 32'(ls), 32'(m.run && (m.k == m.tot - 1)));
      chk({tag, " done"}, 32'(dn), 32'(m.dn));
   endtask

   task automatic chk_models();
      chk_one("n16", m16, a_dout, a_iter, a_busy, a_last, a_done);
      chk_one("n15", m15, b_dout, b_iter, b_busy, b_last, b_done);
   endtask

   task automatic apply(bit st, bit r4, bit hd, bit ab);
      start  = st;
      radix4 = r4;
      hold   = hd;
      abort  = ab;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      chk_models();
   endtask

   // Asynchronous reset pulse between clock edges; called 1 unit after an edge.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst dout", 32'(a_dout), 0);
      chk("rst iter", 32'(a_iter), 0);
      chk("rst flags", {29'd0, a_busy, a_last, a_done}, 0);
      chk_models();
      #1 rst = 1'b0;
   endtask

   typedef struct {
      bit st;
      bit r4;
      bit hd;
      bit ab;
      int dout;
      int iter;
      bit busy;
      bit last;
      bit done;
   } vec_t;

   vec_t tbl[17];
   int   done_at;

   initial begin
      tbl[0]  = '{1, 1, 0, 0, 16, 0, 1, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 14, 1, 1, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 12, 2, 1, 0, 0};
      tbl[3]  = '{0, 0, 1, 0, 12, 2, 1, 0, 0};
      tbl[4]  = '{0, 0, 1, 0, 12, 2, 1, 0, 0};
      tbl[5]  = '{0, 0, 0, 0, 10, 3, 1, 0, 0};
      tbl[6]  = '{0, 0, 0, 0,  8, 4, 1, 0, 0};
      tbl[7]  = '{0, 0, 0, 0,  6, 5, 1, 0, 0};
      tbl[8]  = '{0, 0, 0, 0,  4, 6, 1, 0, 0};
      tbl[9]  = '{0, 0, 0, 0,  2, 7, 1, 1, 0};
      tbl[10] = '{0, 0, 0, 0,  0, 8, 0, 0, 1};
      tbl[11] = '{1, 0, 0, 0, 16, 0, 1, 0, 0};
      tbl[12] = '{0, 1, 0, 0, 15, 1, 1, 0, 0};
      tbl[13] = '{1, 1, 0, 0, 14, 2, 1, 0, 0};
      tbl[14] = '{0, 0, 1, 1,  0, 2, 0, 0, 0};
      tbl[15] = '{0, 0, 1, 1,  0, 2, 0, 0, 0};
      tbl[16] = '{0, 0, 0, 0,  0, 2, 0, 0, 0};

      apply(0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk("reset dout", 32'(a_dout), 0);
      chk("reset flags", {29'd0, a_busy, a_last, a_done}, 0);
      chk_models();
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].st, tbl[i].r4, tbl[i].hd, tbl[i].ab);
         cycle();
         chk($sformatf("tbl%0d dout", i), 32'(a_dout), tbl[i].dout);
         chk($sformatf("tbl%0d iter", i), 32'(a_iter), tbl[i].iter);
         chk($sformatf("tbl%0d flags", i),
             {29'd0, a_busy, a_last, a_done},
             {29'd0, tbl[i].busy, tbl[i].last, tbl[i].done});
      end

      // Radix-2 run with three hold cycles while dout is 9.
      apply(1, 0, 0, 0);
      cycle();
      done_at = 0;
      for (int c = 1; c <= 40; c++) begin
         apply(0, 0, (c >= 8) && (c <= 10), 0);
         cycle();
         if (c == 10) chk("hold dout", 32'(a_dout), 9);
         if (a_done) begin
            done_at = c;
            break;
         end
      end
      chk("hold done edge", done_at, 19);
      chk("hold iter", 32'(a_iter), 16);

      // Abort together with hold at dout 5.
      apply(1, 0, 0, 0);
      cycle();
      for (int c = 0; c < 11; c++) begin
         apply(0, 0, 0, 0);
         cycle();
      end
      chk("pre-abort dout", 32'(a_dout), 5);
      apply(0, 0, 1, 1);
      cycle();
      chk("abort busy", 32'(a_busy), 0);
      chk("abort dout", 32'(a_dout), 0);
      chk("abort iter", 32'(a_iter), 11);
      apply(0, 0, 0, 0);
      cycle();
      chk("abort no done", 32'(a_done), 0);

      // Async reset mid-run, then a clean run.
      apply(1, 1, 0, 0);
      cycle();
      apply(0, 0, 0, 0);
      cycle();
      cycle();
      async_reset();
      apply(1, 0, 0, 0);
      cycle();
      chk("post-rst dout", 32'(a_dout), 16);
      chk("post-rst busy", 32'(a_busy), 1);

      for (int c = 0; c < 1500; c++) begin
         apply($urandom_range(3) == 0, $urandom_range(1) == 1,
               $urandom_range(3) == 0, $urandom_range(19) == 0);
         cycle();
         if ($urandom_range(199) == 0) async_reset();
      end

      apply(0, 0, 0, 0);
      repeat (20) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
